// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, load-op bit positions and types for the MEM stage.
// The EX->MEM bus layout is captured as a packed struct so fields are named, not sliced.
package mem_stage_pkg;

    localparam int unsigned EX_TO_MEM_WD = 81;
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned FWD_WD       = 38;
    localparam int unsigned STALL_WD     = 6;

    localparam int unsigned STALL_MEM = 3;
    localparam int unsigned STALL_WB  = 4;
    localparam logic        STOP      = 1'b1;
    localparam logic        NO_STOP   = 1'b0;

    // One-hot load_op bit positions: {lb, lbu, lh, lhu, lw}
    localparam int unsigned LOAD_LB  = 4;
    localparam int unsigned LOAD_LBU = 3;
    localparam int unsigned LOAD_LH  = 2;
    localparam int unsigned LOAD_LHU = 1;
    localparam int unsigned LOAD_LW  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic [4:0]  load_op;
    } ex_to_mem_t;

    // StLive: SRAM output belongs to the resident instruction; StBuf: it was captured in rdata_buf.
    typedef enum logic [1:0] {
        StNone,
        StLive,
        StBuf
    } rdata_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects and extends the addressed byte/halfword of a data-SRAM read word.
// Unused low address bits are ignored, so misaligned accesses are not detected here.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [4:0]  load_op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // An all-zero load_op falls through to the full word.
    always_comb begin
        result = rdata;
        if (load_op[LOAD_LB]) begin
            result = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op[LOAD_LBU]) begin
            result = {24'd0, byte_sel};
        end else if (load_op[LOAD_LH]) begin
            result = {{16{half_sel[15]}}, half_sel};
        end else if (load_op[LOAD_LHU]) begin
            result = {16'd0, half_sel};
        end else if (load_op[LOAD_LW]) begin
            result = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus under stall/bubble control, keeps the
// one-cycle SRAM read data alive across holds, and drives the WB and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [FWD_WD-1:0]       mem_to_id_bus
);

    ex_to_mem_t   bus_q;
    rdata_state_e state_q, state_d;
    logic [31:0]  rdata_buf_q;
    logic         do_bubble, do_load, do_hold;
    logic         buf_valid;
    logic [31:0]  rdata_eff, load_result, rf_wdata;

    assign do_bubble = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);
    assign do_load   = (stall[STALL_MEM] == NO_STOP);
    assign do_hold   = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == STOP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q <= '0;
        end else if (do_bubble) begin
            bus_q <= '0;
        end else if (do_load) begin
            bus_q <= ex_to_mem_t'(ex_to_mem_bus);
        end
    end

    always_comb begin
        state_d = state_q;
        if (do_bubble) begin
            state_d = StNone;
        end else if (do_load) begin
            state_d = StLive;
        end else if (do_hold && state_q == StLive) begin
            state_d = StBuf;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StNone;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the SRAM word on the first hold edge, before the SRAM output moves on.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf_q <= '0;
        end else if (do_hold && state_q == StLive) begin
            rdata_buf_q <= data_sram_rdata;
        end
    end

    assign buf_valid = (state_q == StBuf);
    assign rdata_eff = buf_valid ? rdata_buf_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .rdata   (rdata_eff),
        .addr_lo (bus_q.ex_result[1:0]),
        .load_op (bus_q.load_op),
        .result  (load_result)
    );

    assign rf_wdata      = bus_q.sel_rf_res ? load_result : bus_q.ex_result;
    assign mem_to_wb_bus = {bus_q.pc, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
    assign mem_to_id_bus = {bus_q.rf_we, bus_q.rf_waddr, rf_wdata};

    // Store controls are consumed in EX; the other stall bits belong to other stages.
    logic unused_bits;
    assign unused_bits = ^{bus_q.data_ram_en, bus_q.data_ram_wen, stall[5], stall[2:0]};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage between EX and WB: registers the EX→MEM bus and applies stall/bubble control.
- Aligns and sign/zero-extends data-SRAM load data, then drives the MEM→WB bus and the MEM→ID forwarding bus.
- Holds the one-cycle-latency SRAM read data in a buffer while the stage is stalled, so the load result is not lost when the SRAM output changes.

Parameters:
- EX_TO_MEM_WD, 81, EX→MEM bus width (from shared defines).
- MEM_TO_WB_WD, 70, MEM→WB bus width: {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- FWD_WD, 38, forwarding bus width: {rf_we, rf_waddr[4:0], rf_wdata[31:0]}.

Ports:
- clk  in  1  clock; everything on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- stall  in  6  StallBus; bit3 = MEM stage, bit4 = WB stage; Stop = 1.
- ex_to_mem_bus  in  81  fields, MSB first: {pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0], load_op[4:0]}.
  - load_op is one-hot: {lb, lbu, lh, lhu, lw}.
- data_sram_rdata  in  32  read data for the request issued in EX; valid only in the first cycle the instruction occupies MEM.
- mem_to_wb_bus  out  70  result toward WB.
- mem_to_id_bus  out  38  forwarding copy of the WB-bound write.

Behaviour:
- Reset (resetn = 0, async): pipeline register, rdata_buf, buf_valid and fresh all clear to 0. Both output buses read 0 while reset is asserted and until the first load.
- Pipeline register update, evaluated at each rising edge in this priority:
  - Bubble: stall[3] = Stop and stall[4] = NoStop. Register ← 0, fresh ← 0, buf_valid ← 0.
  - Load: stall[3] = NoStop. Register ← ex_to_mem_bus, fresh ← 1, buf_valid ← 0.
  - Hold: stall[3] = Stop and stall[4] = Stop. Register unchanged.
    - If fresh = 1: rdata_buf ← data_sram_rdata, buf_valid ← 1, fresh ← 0.
    - Otherwise rdata_buf, buf_valid and fresh are unchanged.
- Read-data hold state machine:
  - States are LIVE (fresh = 1), BUF (buf_valid = 1) and NONE.
  - LIVE goes to BUF on a hold edge.
  - LIVE, BUF and NONE all go to LIVE on a load edge, and to NONE on a bubble edge.
  - Effective rdata = rdata_buf when buf_valid, otherwise data_sram_rdata.
  - In NONE the result never depends on rdata, because a bubble carries sel_rf_res = 0.
- Load alignment (combinational), with a = ex_result[1:0]:
  - lb: sign-extend byte a. lbu: zero-extend byte a.
  - lh: sign-extend halfword selected by a[1]. lhu: zero-extend the same halfword.
  - lw: the full word.
  - Misaligned halfword/word addresses are not checked; the low address bits that the selection does not use are ignored.
  - If load_op is all-zero while sel_rf_res = 1, the load result is the full word.
- Result selection: rf_wdata = sel_rf_res ? load_result : ex_result.
- Output buses:
  - mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata}.
  - mem_to_id_bus = {rf_we, rf_waddr, rf_wdata}.
  - Both are combinational from the register, so latency is one cycle EX→MEM_out.
- Stores (data_ram_wen ≠ 0) are issued in EX. MEM only passes the instruction through; rf_we comes from EX, and EX sets it to 0 for stores.
- A back-to-back load with no stall uses live rdata each cycle and never touches the buffer.
- Reset asserted mid-hold discards buffered data immediately.

Decomposition:
- Shared defines (lib/defines.vh): EX_TO_MEM_WD, MEM_TO_WB_WD, a forwarding-width macro, StallBus, Stop/NoStop, and load_op bit indices.
- One combinational sub-module, load_align. Inputs: rdata[31:0], addr_lo[1:0], load_op[4:0]. Output: result[31:0].
- Pipeline register, hold logic and muxing stay in mem_stage.

Test Plan:
- Reset behaviour: assert resetn = 0 mid-cycle with the register loaded → both buses are 0 immediately, without waiting for a clock edge.
- Load variants: lb, ex_result = 0x1003, rdata = 0x80FF_1234, no stall → rf_wdata = 0xFFFF_FF80.
  - Same rdata with lbu at a = 2 → 0x0000_00FF.
  - lh at a = 2 → 0xFFFF_80FF.
  - lhu at a = 0 → 0x0000_1234.
- Hold across stall: lw loaded with rdata = 0xDEAD_BEEF; hold for 3 cycles while rdata changes to 0x1111_1111.
  - rf_wdata stays 0xDEAD_BEEF for all 3 cycles.
  - Release → the next instruction is loaded and buf_valid = 0.
- Bubble insertion: stall = 6'b001111 at the edge → mem_to_wb_bus = 0 the next cycle, and the pending EX bus is not captured.
- ALU pass-through: sel_rf_res = 0, rf_we = 1, waddr = 5'd9, ex_result = 0x0000_0042, pc = 0xBFC0_0010.
  - mem_to_wb_bus = {0xBFC0_0010, 1, 9, 0x42}.
  - mem_to_id_bus matches the low 38 bits.
- Back-to-back loads: lw then lb with no stall and rdata 0x0000_00AA then 0x0000_007F.
  - Outputs are 0xAA then 0x7F on consecutive cycles.
  - buf_valid stays 0 throughout.
